// File: rtl/pong_game_ctrl_if.sv
// Bundles the frame tick, player and collision inputs and the ball-control outputs of the pong sequencer.
// The master drives frame_tick, serve buttons, collision levels and ball_x, and observes the outputs.
// The slave (the sequencer) consumes those inputs and drives direction, run/home, scores and game_over.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               p1_srv;
  logic               p2_srv;
  logic               p1_c;
  logic               p2_c;
  logic               w_cv;
  logic               w_ch;
  logic [9:0]         ball_x;
  logic [1:0]         bx_delta;
  logic [2:0]         by_delta;
  logic               ball_run;
  logic               ball_home;
  logic               serve_left;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;

  modport master (
    output frame_tick, p1_srv, p2_srv, p1_c, p2_c, w_cv, w_ch, ball_x,
    input  bx_delta, by_delta, ball_run, ball_home, serve_left, score1, score2, game_over
  );

  modport slave (
    input  frame_tick, p1_srv, p2_srv, p1_c, p2_c, w_cv, w_ch, ball_x,
    output bx_delta, by_delta, ball_run, ball_home, serve_left, score1, score2, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve / play / point / game-over FSM, ball direction and both scores.
// Latency: all outputs registered, updated one cycle after a frame_tick; ball_home is a one-cycle pulse.
// Backpressure: none; state advances only on frame_tick, the datapath must accept ball_home on any cycle.
// Ports: clk, rst_n (async active-low) and the slave side of pong_game_ctrl_if.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int POINT_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int CENTER_X     = 320
) (
  input  logic                clk,
  input  logic                rst_n,
  pong_game_ctrl_if.slave     bus
);

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [SCORE_W-1:0] LP_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] LP_ONE  = SCORE_W'(1);
  localparam logic [9:0]         LP_CX   = 10'(CENTER_X);
  localparam logic [7:0]         LP_TMR  = 8'(POINT_FRAMES - 1);

  localparam logic [1:0] DX_POS = 2'b01;
  localparam logic [1:0] DX_NEG = 2'b11;
  localparam logic [2:0] DY_POS = 3'b001;

  logic [1:0]         r_state;
  logic [1:0]         r_bx;
  logic [2:0]         r_by;
  logic               r_run;
  logic               r_home;
  logic               r_serve_left;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_over;
  logic [7:0]         r_timer;
  logic               r_p1_prev;
  logic               r_p2_prev;
  logic               r_cv_prev;
  logic               r_ch_prev;

  // Rising edges relative to the level seen on the previous frame tick, so a
  // sustained overlap yields a single event.
  logic w_p1_rise;
  logic w_p2_rise;
  logic w_cv_rise;
  logic w_ch_rise;
  logic w_win;

  assign w_p1_rise = bus.p1_c & ~r_p1_prev;
  assign w_p2_rise = bus.p2_c & ~r_p2_prev;
  assign w_cv_rise = bus.w_cv & ~r_cv_prev;
  assign w_ch_rise = bus.w_ch & ~r_ch_prev;
  assign w_win     = (r_score1 == LP_WIN) || (r_score2 == LP_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SERVE;
      r_bx         <= 2'b00;
      r_by         <= DY_POS;
      r_run        <= 1'b0;
      r_home       <= 1'b0;
      r_serve_left <= 1'b0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_over       <= 1'b0;
      r_timer      <= 8'd0;
      r_p1_prev    <= 1'b0;
      r_p2_prev    <= 1'b0;
      r_cv_prev    <= 1'b0;
      r_ch_prev    <= 1'b0;
    end else begin
      // ball_home lives for exactly the cycle after the tick that raised it.
      r_home <= 1'b0;
      if (bus.frame_tick) begin
        r_p1_prev <= bus.p1_c;
        r_p2_prev <= bus.p2_c;
        r_cv_prev <= bus.w_cv;
        r_ch_prev <= bus.w_ch;
        case (r_state)
          ST_SERVE: begin
            if (r_serve_left && bus.p1_srv) begin
              r_bx    <= DX_POS;
              r_run   <= 1'b1;
              r_state <= ST_PLAY;
            end else if (!r_serve_left && bus.p2_srv) begin
              r_bx    <= DX_NEG;
              r_run   <= 1'b1;
              r_state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (w_ch_rise) begin
              // Ball left through an edge: the side it exited decides the scorer.
              if (bus.ball_x < LP_CX) begin
                r_score2     <= r_score2 + LP_ONE;
                r_serve_left <= 1'b1;
              end else begin
                r_score1     <= r_score1 + LP_ONE;
                r_serve_left <= 1'b0;
              end
              r_bx    <= 2'b00;
              r_run   <= 1'b0;
              r_timer <= LP_TMR;
              r_state <= ST_POINT;
            end else begin
              // Direction is forced toward the opponent, never toggled; a
              // simultaneous hit on both paddles leaves it as is.
              if (w_p1_rise && !w_p2_rise) begin
                r_bx <= DX_POS;
              end else if (w_p2_rise && !w_p1_rise) begin
                r_bx <= DX_NEG;
              end
              if (w_cv_rise) begin
                r_by <= -r_by;
              end
            end
          end
          ST_POINT: begin
            if (r_timer != 8'd0) begin
              r_timer <= r_timer - 8'd1;
            end else if (w_win) begin
              r_over  <= 1'b1;
              r_state <= ST_OVER;
            end else begin
              r_home  <= 1'b1;
              r_state <= ST_SERVE;
            end
          end
          ST_OVER: begin
            if (bus.p1_srv || bus.p2_srv) begin
              r_score1 <= '0;
              r_score2 <= '0;
              r_over   <= 1'b0;
              r_home   <= 1'b1;
              r_by     <= DY_POS;
              r_state  <= ST_SERVE;
            end
          end
          default: r_state <= ST_SERVE;
        endcase
      end
    end
  end

  assign bus.bx_delta   = r_bx;
  assign bus.by_delta   = r_by;
  assign bus.ball_run   = r_run;
  assign bus.ball_home  = r_home;
  assign bus.serve_left = r_serve_left;
  assign bus.score1     = r_score1;
  assign bus.score2     = r_score2;
  assign bus.game_over  = r_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed ticks push hand-computed expectations,
// a negedge monitor pops one per tick and checks that outputs hold between ticks.
module tb_pong_game_ctrl;

  localparam int PF = 60;

  typedef struct packed {
    logic [1:0] bx;
    logic [2:0] by;
    logic       run;
    logic       home;
    logic       sl;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       over;
  } exp_t;

  logic clk;
  logic rst_n;
  logic tick_d;
  int   n_cmp;
  int   n_err;
  exp_t e;
  exp_t last;
  exp_t rst_exp;
  exp_t q[$];

  pong_game_ctrl_if #(.SCORE_W(4)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE   (7),
    .POINT_FRAMES(PF),
    .SCORE_W     (4),
    .CENTER_X    (320)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= bus.frame_tick;
  end

  function automatic exp_t actual();
    exp_t a;
    a.bx   = bus.bx_delta;
    a.by   = bus.by_delta;
    a.run  = bus.ball_run;
    a.home = bus.ball_home;
    a.sl   = bus.serve_left;
    a.s1   = bus.score1;
    a.s2   = bus.score2;
    a.over = bus.game_over;
    return a;
  endfunction

  task automatic check(input exp_t want, input string name);
    exp_t got;
    got = actual();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got bx=%b by=%b run=%b home=%b sl=%b s1=%0d s2=%0d over=%b, want bx=%b by=%b run=%b home=%b sl=%b s1=%0d s2=%0d over=%b",
               name, $time, got.bx, got.by, got.run, got.home, got.sl, got.s1, got.s2, got.over,
               want.bx, want.by, want.run, want.home, want.sl, want.s1, want.s2, want.over);
    end
  endtask

  // Monitor: one expectation per tick; between ticks outputs must hold with ball_home low.
  always @(negedge clk) begin
    if (!rst_n) begin
      check(rst_exp, "reset");
      last = rst_exp;
    end else if (tick_d) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tick_no_expect @%0t: got output update, want queued expectation", $time);
      end else begin
        exp_t w;
        w = q.pop_front();
        check(w, "tick");
        last = w;
        last.home = 1'b0;
      end
    end else begin
      check(last, "hold");
    end
  end

  task automatic tick(input logic s1, input logic s2, input logic c1, input logic c2,
                      input logic cv, input logic ch);
    bus.p1_srv     = s1;
    bus.p2_srv     = s2;
    bus.p1_c       = c1;
    bus.p2_c       = c2;
    bus.w_cv       = cv;
    bus.w_ch       = ch;
    bus.frame_tick = 1'b1;
    q.push_back(e);
    e.home = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Frozen ball after a point: collision wiggles are ignored, last tick reloads or ends the game.
  task automatic point_wait(input bit to_over);
    tick(0, 0, 1, 0, 1, 0);
    repeat (PF - 2) tick(0, 0, 0, 0, 0, 0);
    if (to_over) e.over = 1'b1;
    else         e.home = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_exp = '{bx:2'b00, by:3'b001, run:1'b0, home:1'b0, sl:1'b0, s1:4'd0, s2:4'd0, over:1'b0};
    e    = rst_exp;
    last = rst_exp;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.p1_srv = 1'b0;
    bus.p2_srv = 1'b0;
    bus.p1_c   = 1'b0;
    bus.p2_c   = 1'b0;
    bus.w_cv   = 1'b0;
    bus.w_ch   = 1'b0;
    bus.ball_x = 10'd0;
    repeat (3) @(negedge clk);
    #7 rst_n = 1'b1;
    @(negedge clk);

    // Non-serving player's button is ignored.
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    // Right player serves.
    e.bx = 2'b11; e.run = 1'b1;
    tick(0, 1, 0, 0, 0, 0);

    // Paddle hits force direction; sustained overlap acts once.
    e.bx = 2'b01;
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    e.bx = 2'b11;
    tick(0, 0, 0, 1, 0, 0);
    repeat (4) tick(0, 0, 0, 1, 0, 0);
    e.bx = 2'b01;
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Wall and paddle on the same tick.
    e.bx = 2'b11;
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    e.bx = 2'b01; e.by = 3'b111;
    tick(0, 0, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    // Both paddles at once: direction unchanged.
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Left-side exit with a paddle hit on the same tick: right player scores.
    bus.ball_x = 10'd5;
    e.s2 = 4'd1; e.sl = 1'b1; e.bx = 2'b00; e.run = 1'b0;
    tick(0, 0, 0, 1, 0, 1);
    point_wait(1'b0);
    tick(0, 1, 0, 0, 0, 0);
    e.bx = 2'b01; e.run = 1'b1;
    tick(1, 0, 0, 0, 0, 0);

    // Left player scores seven times; the seventh ends the game.
    bus.ball_x = 10'd630;
    for (int i = 1; i <= 7; i++) begin
      e.s1 = 4'(i); e.sl = 1'b0; e.bx = 2'b00; e.run = 1'b0;
      tick(0, 0, 0, 0, 0, 1);
      point_wait(i == 7);
      if (i < 7) begin
        e.bx = 2'b11; e.run = 1'b1;
        tick(0, 1, 0, 0, 0, 0);
      end
    end

    // OVER holds until a button, then clears scores and reloads the ball.
    tick(0, 0, 0, 0, 0, 0);
    e.s1 = 4'd0; e.s2 = 4'd0; e.over = 1'b0; e.home = 1'b1; e.by = 3'b001;
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a point countdown.
    e.bx = 2'b11; e.run = 1'b1;
    tick(0, 1, 0, 0, 0, 0);
    bus.ball_x = 10'd5;
    e.s2 = 4'd1; e.sl = 1'b1; e.bx = 2'b00; e.run = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    repeat (29) tick(0, 0, 0, 0, 0, 0);
    #7 rst_n = 1'b0;
    e = rst_exp;
    repeat (3) @(negedge clk);
    #7 rst_n = 1'b1;
    @(negedge clk);
    repeat (5) tick(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the pong core. It owns serve, play, point and game-over sequencing, along with ball direction and the two player scores. It consumes the per-frame tick, serve buttons and collision flags, and drives the ball-motion datapath (deltas, run enable, home reload). It replaces the collision-edge-clocked direction logic with a fully synchronous FSM.

Parameters:
WIN_SCORE, 7, score that ends the game (1..2^SCORE_W-1)
POINT_FRAMES, 60, frames the ball is frozen after a point (1..255)
SCORE_W, 4, width of each score counter
CENTER_X, 320, ball_x threshold deciding which side the ball exited

Ports:
clk  in  1  system clock; one clock
rst_n  in  1  reset; asynchronous, active-low
frame_tick  in  1  one-cycle pulse per frame (vsync falling edge)
p1_srv  in  1  left player serve button, level, pre-synchronised
p2_srv  in  1  right player serve button, level, pre-synchronised
p1_c  in  1  ball/left paddle overlap, level
p2_c  in  1  ball/right paddle overlap, level
w_cv  in  1  ball at top/bottom wall, level
w_ch  in  1  ball at left/right screen edge, level
ball_x  in  10  current ball x position
bx_delta  out  2  signed x direction: -1, 0, +1
by_delta  out  3  signed y direction: -1 or +1
ball_run  out  1  datapath applies deltas on frame_tick when high
ball_home  out  1  one-cycle pulse; datapath reloads ball to serve position
serve_left  out  1  1: left player serves next; 0: right player serves next
score1  out  SCORE_W  left player score
score2  out  SCORE_W  right player score
game_over  out  1  high in OVER state

Behaviour:
- All outputs are registered. State and outputs change only on cycles where frame_tick=1; all other cycles hold.
- Reset (async, any time, including mid-point or mid-timer) sets:
  - state=SERVE_WAIT, bx_delta=0, by_delta=+1, ball_run=0, ball_home=0
  - serve_left=0, score1=score2=0, game_over=0, timer=0, all collision history=0
- Collision edges:
  - p1_c, p2_c, w_cv and w_ch are sampled into prev registers on every frame_tick, in every state.
  - An event is rise = level & ~prev, evaluated at frame_tick only. A sustained overlap therefore produces exactly one event.
- States:
  - SERVE_WAIT: bx_delta=0, ball_run=0.
    - serve_left=1 & p1_srv: bx_delta=+1, go PLAY.
    - serve_left=0 & p2_srv: bx_delta=-1, go PLAY.
    - The non-serving player's button is ignored.
  - PLAY: ball_run=1. Priority per tick:
    - 1) w_ch rise scores a point:
      - ball_x<CENTER_X: score2+1, serve_left=1.
      - otherwise: score1+1, serve_left=0.
      - Then bx_delta=0, ball_run=0, timer=POINT_FRAMES-1, go POINT. Other events that tick are discarded.
    - 2) Paddle events:
      - p1_c rise: bx_delta=+1.
      - p2_c rise: bx_delta=-1.
      - Both rise: bx_delta unchanged.
      - Direction is forced, never negated, so no double flip is possible.
    - 3) w_cv rise: by_delta negated. This is independent of, and applies in the same tick as, a paddle event.
  - POINT: ball_run=0.
    - timer>0: decrement.
    - timer==0 and (score1==WIN_SCORE or score2==WIN_SCORE): go OVER.
    - timer==0 otherwise: ball_home=1 for exactly that one cycle, go SERVE_WAIT.
  - OVER: game_over=1, ball_run=0.
    - p1_srv|p2_srv: score1=score2=0, game_over=0, ball_home pulse, by_delta=+1, go SERVE_WAIT. serve_left is kept.
- Scores never exceed WIN_SCORE. No wrap is possible because OVER is entered first.
- Collision inputs are ignored outside PLAY; only their history is updated.
- Latency: outputs change the cycle after the frame_tick. The datapath consuming frame_tick on the same cycle moves with the previous values, i.e. a direction change takes effect on the next frame.
- The ball_home pulse coincides with a non-tick cycle. The datapath must accept the reload at any cycle.

Test Plan:
- Reset, frame_ticks with p1_srv=1 -> stays SERVE_WAIT, bx_delta=0. Assert p2_srv on a tick -> bx_delta=-1 (2'b11), ball_run=1 next cycle.
- PLAY, hold p2_c=1 for 5 ticks -> bx_delta=+1? No: p2_c forces -1. With ball moving +1, it becomes -1 once; held overlap causes no further change. Then p1_c rise -> bx_delta=+1.
- PLAY, w_cv and p1_c rise on the same tick -> by_delta +1→-1 and bx_delta=+1 together.
- PLAY, ball_x=5, w_ch rise with p2_c rise on the same tick -> score2=1, serve_left=1, bx_delta=0. After POINT_FRAMES ticks, a single-cycle ball_home and SERVE_WAIT; p1_srv -> bx_delta=+1.
- score1=6, WIN_SCORE=7, ball_x=630 w_ch rise -> score1=7, after POINT_FRAMES ticks game_over=1. p2_srv tick -> scores 0, ball_home pulse, SERVE_WAIT.
- Assert rst_n low mid-POINT with timer=30 -> all outputs immediately at reset values, no ball_home pulse after release.
